// File: rtl/cpu_pkg.sv
// Shared widths for the decode/execute datapath: register file, scoreboard and ID/EX.
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PEND_W   = 2;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/pend_counter.sv
// Pending-write counter for one register: counts issued-but-not-written-back results.
module pend_counter #(
    parameter int PEND_W = cpu_pkg::PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              is_zero,
    output logic              is_one,
    output logic              is_max,
    output logic              underflow
);

    assign is_zero   = (cnt == '0);
    assign is_one    = (cnt == PEND_W'(1));
    assign is_max    = (cnt == '1);
    assign underflow = dec & ~inc & is_zero;

    // Increment at max is blocked upstream by the WAW stall, so no saturation guard is needed here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec && !inc && !is_zero) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with writeback bypass and per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int PEND_W = cpu_pkg::PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_wen,
    output logic              id_stall,
    output logic              id_fire,
    output logic [DATA_W-1:0] issue_data_1,
    output logic [DATA_W-1:0] issue_data_2,
    output logic [ADDR_W-1:0] issue_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              sb_err
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend_zero;
    logic [NUM_REGS-1:0] pend_one;
    logic [NUM_REGS-1:0] pend_max;
    logic [NUM_REGS-1:0] pend_uf;
    logic [PEND_W-1:0]   pend_cnt_unused [NUM_REGS];
    logic                byp_1;
    logic                byp_2;
    logic                haz_1;
    logic                haz_2;
    logic                haz_waw;

    // r0 has no counter: it is never pending and never reports underflow.
    assign pend_zero[0]       = 1'b1;
    assign pend_one[0]        = 1'b0;
    assign pend_max[0]        = 1'b0;
    assign pend_uf[0]         = 1'b0;
    assign pend_cnt_unused[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
        pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (id_fire & id_wen & (id_rd == ADDR_W'(r))),
            .dec       (wb_en & (wb_rd == ADDR_W'(r))),
            .clr       (flush),
            .cnt       (pend_cnt_unused[r]),
            .is_zero   (pend_zero[r]),
            .is_one    (pend_one[r]),
            .is_max    (pend_max[r]),
            .underflow (pend_uf[r])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_err <= 1'b0;
        end else if (|pend_uf) begin
            sb_err <= 1'b1;
        end
    end

    always_comb begin
        byp_1        = wb_en && (wb_rd == id_rs1) && (id_rs1 != '0);
        byp_2        = wb_en && (wb_rd == id_rs2) && (id_rs2 != '0);
        issue_data_1 = byp_1 ? wb_data : regs[id_rs1];
        issue_data_2 = byp_2 ? wb_data : regs[id_rs2];
        // A single outstanding write that retires this cycle is covered by the bypass.
        haz_1        = id_use_rs1 && !pend_zero[id_rs1] && !(pend_one[id_rs1] && byp_1);
        haz_2        = id_use_rs2 && !pend_zero[id_rs2] && !(pend_one[id_rs2] && byp_2);
        haz_waw      = id_wen && pend_max[id_rd];
        id_stall     = id_valid && (haz_1 || haz_2 || haz_waw);
        id_fire      = id_valid && !id_stall;
        issue_rd     = (id_fire && id_wen) ? id_rd : '0;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a behavioural reference model and expectation queue.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_stall;
    logic        id_fire;
    logic [31:0] issue_data_1;
    logic [31:0] issue_data_2;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        sb_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_wen       (id_wen),
        .id_stall     (id_stall),
        .id_fire      (id_fire),
        .issue_data_1 (issue_data_1),
        .issue_data_2 (issue_data_2),
        .issue_rd     (issue_rd),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .sb_err       (sb_err)
    );

    typedef struct {
        string       tag;
        logic        stall;
        logic        fire;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  ird;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mregs [32];
    int          mpend [32];
    logic        merr;

    function automatic logic m_stall();
        logic h;
        h = 1'b0;
        if (id_use_rs1 && id_rs1 != 0 && mpend[id_rs1] != 0 &&
            !(mpend[id_rs1] == 1 && wb_en && wb_rd == id_rs1)) h = 1'b1;
        if (id_use_rs2 && id_rs2 != 0 && mpend[id_rs2] != 0 &&
            !(mpend[id_rs2] == 1 && wb_en && wb_rd == id_rs2)) h = 1'b1;
        if (id_wen && id_rd != 0 && mpend[id_rd] == 3) h = 1'b1;
        return id_valid && h;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (wb_en && wb_rd == rs) return wb_data;
        return mregs[rs];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; id_rd = '0; id_wen = 1'b0; wb_en = 1'b0; wb_rd = '0;
        wb_data = '0; flush = 1'b0;
    endtask

    task automatic eval(input string tag);
        exp_t e;
        e.tag   = tag;
        e.stall = m_stall();
        e.fire  = id_valid && !e.stall;
        e.d1    = m_read(id_rs1);
        e.d2    = m_read(id_rs2);
        e.ird   = (e.fire && id_wen) ? id_rd : 5'd0;
        e.err   = merr;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".stall"}, 32'(id_stall), 32'(e.stall));
        chk({e.tag, ".fire"},  32'(id_fire),  32'(e.fire));
        chk({e.tag, ".d1"},    issue_data_1,  e.d1);
        chk({e.tag, ".d2"},    issue_data_2,  e.d2);
        chk({e.tag, ".rd"},    32'(issue_rd), 32'(e.ird));
        chk({e.tag, ".err"},   32'(sb_err),   32'(e.err));
    endtask

    task automatic adv();
        logic f;
        int   ir;
        int   dr;
        f  = id_valid && !m_stall();
        ir = (f && id_wen && id_rd != 0) ? int'(id_rd) : -1;
        dr = (wb_en && wb_rd != 0) ? int'(wb_rd) : -1;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = '0;
                mpend[i] = 0;
            end
            merr = 1'b0;
        end else begin
            if (dr >= 0) mregs[dr] = wb_data;
            if (dr >= 0 && dr != ir && mpend[dr] == 0) merr = 1'b1;
            if (flush) begin
                for (int i = 0; i < 32; i++) mpend[i] = 0;
            end else if (ir != dr) begin
                if (ir >= 0) mpend[ir]++;
                if (dr >= 0 && mpend[dr] > 0) mpend[dr]--;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        merr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mpend[i] = 0;
        end

        // Reset, then read r1/r2.
        idle(); rst = 1'b0; adv(); adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2;
        eval("t1_reset_read");
        chk("t1_d1_zero", issue_data_1, 32'h0);
        chk("t1_stall_zero", 32'(id_stall), 32'h0);
        chk("t1_err_zero", 32'(sb_err), 32'h0);
        adv();
        // Unscoreboarded write to r1 sets sb_err; reset with a writeback pending must clear all.
        idle(); wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1111_1111;
        eval("t1_wb_r1"); adv();
        idle(); eval("t1_err_set"); chk("t1_err_one", 32'(sb_err), 32'h1); adv();
        idle(); rst = 1'b0; wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h2222_2222; adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2;
        eval("t1_after_reset_wb");
        chk("t1_r1_cleared", issue_data_1, 32'h0);
        chk("t1_r2_unwritten", issue_data_2, 32'h0);
        chk("t1_err_cleared", 32'(sb_err), 32'h0);
        adv();

        // RAW hazard on r5, released by same-cycle writeback bypass.
        idle(); id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd5;
        eval("t2_issue5"); chk("t2_issue_rd", 32'(issue_rd), 32'd5); adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
        eval("t2_raw"); chk("t2_raw_stall", 32'(id_stall), 32'h1); adv();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        eval("t2_bypass");
        chk("t2_bypass_stall", 32'(id_stall), 32'h0);
        chk("t2_bypass_data", issue_data_1, 32'hDEAD_BEEF);
        adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
        eval("t2_array");
        chk("t2_array_stall", 32'(id_stall), 32'h0);
        chk("t2_array_data", issue_data_1, 32'hDEAD_BEEF);
        adv();

        // WAW saturation on r7.
        for (int k = 0; k < 3; k++) begin
            idle(); id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd7;
            eval("t3_fill"); adv();
        end
        eval("t3_full"); chk("t3_full_stall", 32'(id_stall), 32'h1); adv();
        idle(); wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h7;
        eval("t3_wb_only"); adv();
        idle(); id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd7; wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        eval("t3_inc_dec"); chk("t3_inc_dec_fire", 32'(id_fire), 32'h1); adv();
        idle(); id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd7;
        eval("t3_refill"); chk("t3_refill_stall", 32'(id_stall), 32'h0); adv();
        eval("t3_full2"); chk("t3_full2_stall", 32'(id_stall), 32'h1); adv();
        for (int k = 0; k < 3; k++) begin
            idle(); wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h700 + 32'(k);
            eval("t3_drain"); adv();
        end

        // Register zero.
        idle(); wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; id_rs1 = 5'd0;
        eval("t4_wb0"); chk("t4_wb0_nobypass", issue_data_1, 32'h0); adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
        eval("t4_read0"); chk("t4_read0_data", issue_data_1, 32'h0); adv();
        idle(); id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd0;
        eval("t4_issue0"); chk("t4_issue0_rd", 32'(issue_rd), 32'h0); adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        eval("t4_use0"); chk("t4_use0_stall", 32'(id_stall), 32'h0); adv();

        // Flush alongside writeback; later writeback underflows.
        idle(); id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd3;
        eval("t5_issue3"); adv();
        idle(); flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333;
        eval("t5_flush_wb"); adv();
        idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
        eval("t5_after_flush");
        chk("t5_stall", 32'(id_stall), 32'h0);
        chk("t5_data", issue_data_1, 32'h3333);
        chk("t5_err_clear", 32'(sb_err), 32'h0);
        adv();
        idle(); wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h4444;
        eval("t5_underflow"); adv();
        idle(); eval("t5_err"); chk("t5_err_set", 32'(sb_err), 32'h1); adv();
        eval("t5_err_sticky"); chk("t5_err_sticky", 32'(sb_err), 32'h1); adv();

        // Back-to-back issues with writebacks streaming r1..r31 one cycle behind.
        for (int i = 1; i <= 32; i++) begin
            idle(); id_valid = 1'b1;
            if (i <= 31) begin
                id_wen = 1'b1; id_rd = 5'(i);
            end
            if (i >= 2) begin
                wb_en = 1'b1; wb_rd = 5'(i - 1); wb_data = $urandom;
                id_use_rs1 = 1'b1; id_rs1 = 5'(i - 1);
                id_use_rs2 = 1'b1; id_rs2 = 5'($urandom_range(i - 2, 0));
            end
            eval("t6_stream");
            chk("t6_no_stall", 32'(id_stall), 32'h0);
            adv();
        end
        for (int r = 0; r < 32; r += 2) begin
            idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
            id_rs1 = 5'(r); id_rs2 = 5'(r + 1);
            eval("t6_final_read"); adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
